// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl
// Brief    : Multi-cycle MIPS-subset control FSM. It runs FETCH, DECODE, EXE,
//            MEM and WB states. The outputs are decoded from the current state
//            and the instruction.
// Options  : MEM_HANDSHAKE_EN makes FETCH and MEM wait for mem_ready.
// Revision : 1.0 - initial release
// ============================================================================
module mc_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        pc_we,
    output logic        ir_we,
    output logic        regwrite,
    output logic        memwrite,
    output logic        alusrc,
    output logic [1:0]  regdst,
    output logic [1:0]  memtoreg,
    output logic [1:0]  ext_op,
    output logic [2:0]  npc_sel,
    output logic [2:0]  alu_ctr,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'b000,
        S_DECODE = 3'b001,
        S_EXE    = 3'b010,
        S_MEM    = 3'b011,
        S_WB     = 3'b100
    } state_t;

    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_ori   = 6'h0D;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_lui   = 6'h0F;
    localparam logic [5:0] c_op_jal   = 6'h03;
    localparam logic [5:0] c_fn_addu  = 6'h21;
    localparam logic [5:0] c_fn_subu  = 6'h23;
    localparam logic [5:0] c_fn_jr    = 6'h08;

    localparam logic [2:0] c_npc_seq  = 3'b000;
    localparam logic [2:0] c_npc_br   = 3'b001;
    localparam logic [2:0] c_npc_jmp  = 3'b010;
    localparam logic [2:0] c_npc_reg  = 3'b011;
    localparam logic [2:0] c_alu_add  = 3'b000;
    localparam logic [2:0] c_alu_sub  = 3'b001;
    localparam logic [2:0] c_alu_or   = 3'b010;

    state_t     r_state;
    state_t     w_next;
    logic       w_mem_done;
    logic       w_regwrite;
    logic       w_memwrite;
    logic [5:0] w_op;
    logic [5:0] w_fn;
    logic       w_addu, w_subu, w_jr, w_ori, w_lw, w_sw, w_beq, w_lui, w_jal;
    logic       w_illegal;
    logic       w_wb_instr;

`ifdef MEM_HANDSHAKE_EN
    logic w_unused;
    assign w_unused   = ^instr[25:6];
    assign w_mem_done = mem_ready;
`else
    // Without the handshake every memory access completes in one cycle.
    logic w_unused;
    assign w_unused   = ^{instr[25:6], mem_ready};
    assign w_mem_done = 1'b1;
`endif

    assign w_op = instr[31:26];
    assign w_fn = instr[5:0];

    assign w_addu = (w_op == c_op_rtype) && (w_fn == c_fn_addu);
    assign w_subu = (w_op == c_op_rtype) && (w_fn == c_fn_subu);
    assign w_jr   = (w_op == c_op_rtype) && (w_fn == c_fn_jr);
    assign w_ori  = (w_op == c_op_ori);
    assign w_lw   = (w_op == c_op_lw);
    assign w_sw   = (w_op == c_op_sw);
    assign w_beq  = (w_op == c_op_beq);
    assign w_lui  = (w_op == c_op_lui);
    assign w_jal  = (w_op == c_op_jal);

    assign w_illegal  = !(w_addu || w_subu || w_jr || w_ori || w_lw ||
                          w_sw || w_beq || w_lui || w_jal);
    assign w_wb_instr = w_addu || w_subu || w_ori || w_lui || w_lw || w_jal;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = w_mem_done ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (w_jal)          w_next = S_WB;
                else if (w_illegal) w_next = S_FETCH;
                else                w_next = S_EXE;
            end
            S_EXE: begin
                if (w_lw || w_sw)                           w_next = S_MEM;
                else if (w_addu || w_subu || w_ori || w_lui) w_next = S_WB;
                else                                        w_next = S_FETCH;
            end
            S_MEM: begin
                if (!w_mem_done) w_next = S_MEM;
                else if (w_lw)   w_next = S_WB;
                else             w_next = S_FETCH;
            end
            S_WB:    w_next = S_FETCH;
            default: w_next = S_FETCH;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        w_regwrite = 1'b0;
        w_memwrite = 1'b0;
        alusrc     = 1'b0;
        regdst     = 2'b00;
        memtoreg   = 2'b00;
        ext_op     = 2'b00;
        npc_sel    = c_npc_seq;
        alu_ctr    = c_alu_add;
        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = w_mem_done;
                pc_we   = w_mem_done;
            end
            S_EXE: begin
                alusrc = !(w_addu || w_subu || w_beq || w_jr);
                if (w_lui)      ext_op = 2'b10;
                else if (w_ori) ext_op = 2'b00;
                else            ext_op = 2'b01;
                if (w_ori || w_lui)       alu_ctr = c_alu_or;
                else if (w_subu || w_beq) alu_ctr = c_alu_sub;
                if (w_beq) begin
                    npc_sel = c_npc_br;
                    pc_we   = zero;
                end else if (w_jr) begin
                    npc_sel = c_npc_reg;
                    pc_we   = 1'b1;
                end
            end
            S_MEM: begin
                mem_req    = 1'b1;
                w_memwrite = w_sw;
            end
            S_WB: begin
                w_regwrite = w_wb_instr;
                if (w_addu || w_subu) regdst = 2'b01;
                if (w_lw)             memtoreg = 2'b01;
                if (w_jal) begin
                    regdst   = 2'b10;
                    memtoreg = 2'b10;
                    pc_we    = 1'b1;
                    npc_sel  = c_npc_jmp;
                end
            end
            default: ;
        endcase
    end

    // The reset cycle must never commit a write of the instruction being aborted.
    assign regwrite = w_regwrite && reset;
    assign memwrite = w_memwrite && reset;
    assign state    = r_state;

endmodule
`default_nettype wire
